// File: rtl/blit_pkg.sv
// Shared constants, FSM state type and frame-buffer address helper for the sprite blitter.
package blit_pkg;

   localparam int unsigned SPR_W  = 32;
   localparam int unsigned SPR_H  = 32;
   localparam int unsigned SCR_W  = 512;
   localparam int unsigned SCR_H  = 448;
   localparam logic [3:0]  TRANSP = 4'h0;

   localparam int unsigned ColW = $clog2(SPR_W);
   localparam int unsigned RowW = $clog2(SPR_H);
   localparam int unsigned ScrXW = $clog2(SCR_W);

   typedef enum logic [1:0] {StIdle, StFetch, StWrite, StDone} state_e;

   // Row pitch is a power of two, so the linear address is a plain concat.
   function automatic logic [17:0] fb_addr(input logic [9:0] sx, input logic [9:0] sy);
      return {sy[8:0], sx[ScrXW-1:0]};
   endfunction

endpackage

// File: rtl/sprite_blitter.sv
// Copies one 32x32 4-bit sprite from a registered ROM into the frame buffer,
// skipping transparent and off-screen pixels.
module sprite_blitter
   import blit_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start_i,
   input  logic [8:0]  pos_x_i,
   input  logic [8:0]  pos_y_i,
   input  logic [2:0]  spr_sel_i,
   output logic [2:0]  spr_sel_o,
   output logic [9:0]  spr_addr_o,
   input  logic [3:0]  spr_data_i,
   output logic        fb_we_o,
   output logic [17:0] fb_addr_o,
   output logic [3:0]  fb_data_o,
   input  logic        fb_ready_i,
   output logic        busy_o,
   output logic        done_o
);

   state_e            state_q, state_d;
   logic [RowW-1:0]   row_q, row_d;
   logic [ColW-1:0]   col_q, col_d;
   logic [8:0]        pos_x_q, pos_x_d;
   logic [8:0]        pos_y_q, pos_y_d;
   logic [2:0]        sel_q, sel_d;
   logic              fb_we_q, fb_we_d;
   logic [17:0]       fb_addr_q, fb_addr_d;
   logic [3:0]        fb_data_q, fb_data_d;

   logic [9:0]        sx, sy;
   logic              skip, last_px, done;

   always_comb begin
      state_d   = state_q;
      row_d     = row_q;
      col_d     = col_q;
      pos_x_d   = pos_x_q;
      pos_y_d   = pos_y_q;
      sel_d     = sel_q;
      fb_we_d   = fb_we_q;
      fb_addr_d = fb_addr_q;
      fb_data_d = fb_data_q;
      done      = 1'b0;

      sx      = {1'b0, pos_x_q} + 10'(col_q);
      sy      = {1'b0, pos_y_q} + 10'(row_q);
      skip    = (spr_data_i == TRANSP) || (sx >= 10'(SCR_W)) || (sy >= 10'(SCR_H));
      last_px = (row_q == RowW'(SPR_H - 1)) && (col_q == ColW'(SPR_W - 1));

      if (fb_we_q && fb_ready_i) begin
         fb_we_d = 1'b0;
      end

      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               pos_x_d = pos_x_i;
               pos_y_d = pos_y_i;
               sel_d   = spr_sel_i;
               row_d   = '0;
               col_d   = '0;
               state_d = StFetch;
            end
         end
         StFetch: begin
            state_d = StWrite;
         end
         StWrite: begin
            // A pending write must be accepted before the next one can be registered;
            // the ROM address is held, so spr_data_i stays valid while waiting.
            if (!fb_we_q) begin
               if (!skip) begin
                  fb_we_d   = 1'b1;
                  fb_addr_d = fb_addr(sx, sy);
                  fb_data_d = spr_data_i;
               end
               {row_d, col_d} = {row_q, col_q} + 10'd1;
               state_d        = last_px ? StDone : StFetch;
            end
         end
         StDone: begin
            if (!fb_we_q || fb_ready_i) begin
               done    = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StIdle;
         row_q     <= '0;
         col_q     <= '0;
         pos_x_q   <= '0;
         pos_y_q   <= '0;
         sel_q     <= '0;
         fb_we_q   <= 1'b0;
         fb_addr_q <= '0;
         fb_data_q <= '0;
      end else begin
         state_q   <= state_d;
         row_q     <= row_d;
         col_q     <= col_d;
         pos_x_q   <= pos_x_d;
         pos_y_q   <= pos_y_d;
         sel_q     <= sel_d;
         fb_we_q   <= fb_we_d;
         fb_addr_q <= fb_addr_d;
         fb_data_q <= fb_data_d;
      end
   end

   assign spr_sel_o  = sel_q;
   assign spr_addr_o = {row_q, col_q};
   assign fb_we_o    = fb_we_q;
   assign fb_addr_o  = fb_addr_q;
   assign fb_data_o  = fb_data_q;
   assign busy_o     = (state_q != StIdle);
   assign done_o     = done;

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed self-checking bench for sprite_blitter with a registered sprite ROM model.
module tb_sprite_blitter;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [8:0]  pos_x;
   logic [8:0]  pos_y;
   logic [2:0]  spr_sel;
   logic [2:0]  spr_sel_out;
   logic [9:0]  spr_addr;
   logic [3:0]  spr_data;
   logic        fb_we;
   logic [17:0] fb_addr;
   logic [3:0]  fb_data;
   logic        fb_ready;
   logic        busy;
   logic        done;

   logic [3:0]  rom [1024];

   int checks = 0;
   int errors = 0;

   // Results of the most recent blit
   int n_wr, first_addr, last_addr, max_addr, done_cnt, done_k;
   int data_bad, order_bad, stable_bad, busy_low, sel_bad;

   sprite_blitter u_dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .start_i    (start),
      .pos_x_i    (pos_x),
      .pos_y_i    (pos_y),
      .spr_sel_i  (spr_sel),
      .spr_sel_o  (spr_sel_out),
      .spr_addr_o (spr_addr),
      .spr_data_i (spr_data),
      .fb_we_o    (fb_we),
      .fb_addr_o  (fb_addr),
      .fb_data_o  (fb_data),
      .fb_ready_i (fb_ready),
      .busy_o     (busy),
      .done_o     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) spr_data <= rom[spr_addr];

   task automatic check(input string tag, input longint obs, input longint exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic fill_rom(input int mode);
      for (int i = 0; i < 1024; i++) begin
         if (mode == 0) rom[i] = 4'h0;
         else if (mode == 1) rom[i] = 4'h5;
         else rom[i] = 4'(i % 16);
      end
   endtask

   // Runs one blit; stall = cycles FbReady is held low per write, mid_k = cycle to
   // re-pulse Start (0 = never), abort_at = write count at which reset hits (-1 = never).
   task automatic blit(input int px, input int py, input int stall, input int mid_k,
                       input int abort_at);
      int k, st_cnt, prev, idx;
      logic [17:0] h_addr;
      logic [3:0]  h_data;
      n_wr = 0; first_addr = -1; last_addr = -1; max_addr = -1; done_cnt = 0;
      done_k = -1; data_bad = 0; order_bad = 0; stable_bad = 0; busy_low = 0; sel_bad = 0;
      st_cnt = 0; prev = -1; h_addr = '0; h_data = '0;
      @(negedge clk);
      pos_x = 9'(px); pos_y = 9'(py); spr_sel = 3'b101; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 1;
      while (k < 20000) begin
         if (mid_k != 0 && k == mid_k) begin
            start = 1'b1; pos_x = 9'(px + 77); spr_sel = 3'b010;
         end else begin
            start = 1'b0;
         end
         if (!busy) busy_low++;
         if (spr_sel_out != 3'b101) sel_bad++;
         if (fb_we && abort_at >= 0 && n_wr == abort_at) begin
            rst_n = 1'b0;
            #1;
            check("abort_we_low", fb_we, 0);
            check("abort_busy_low", busy, 0);
            for (int j = 0; j < 4; j++) begin
               @(negedge clk);
               if (done || fb_we) done_cnt++;
            end
            rst_n = 1'b1;
            start = 1'b0;
            return;
         end
         if (fb_we) begin
            if (st_cnt == 0) begin
               h_addr = fb_addr; h_data = fb_data;
            end else if (fb_addr != h_addr || fb_data != h_data) begin
               stable_bad++;
            end
            if (st_cnt < stall) begin
               fb_ready = 1'b0;
               st_cnt++;
            end else begin
               fb_ready = 1'b1;
               st_cnt = 0;
               n_wr++;
               if (first_addr < 0) first_addr = int'(fb_addr);
               last_addr = int'(fb_addr);
               if (int'(fb_addr) > max_addr) max_addr = int'(fb_addr);
               if (int'(fb_addr) <= prev) order_bad++;
               prev = int'(fb_addr);
               idx = ((int'(fb_addr) >> 9) - py) * 32 + ((int'(fb_addr) & 511) - px);
               if (idx < 0 || idx > 1023) data_bad++;
               else if (fb_data != rom[idx]) data_bad++;
            end
         end else begin
            fb_ready = 1'b1;
         end
         #1;
         if (done) begin
            done_cnt++;
            done_k = k;
            break;
         end
         @(negedge clk);
         k++;
      end
      start = 1'b0;
      // Confirm no second Done and that the block returned to idle.
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         if (done) done_cnt++;
      end
      check("idle_after_done", busy, 0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; pos_x = '0; pos_y = '0; spr_sel = '0; fb_ready = 1'b1;
      fill_rom(0);
      #12;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_we", fb_we, 0);
      check("rst_addr", fb_addr, 0);
      check("rst_data", fb_data, 0);
      check("rst_spr_addr", spr_addr, 0);
      check("rst_sel", spr_sel_out, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // All transparent
      blit(0, 0, 0, 0, -1);
      check("t1_writes", n_wr, 0);
      check("t1_done_cycle", done_k, 2049);
      check("t1_done_cnt", done_cnt, 1);
      check("t1_busy", busy_low, 0);
      check("t1_sel", sel_bad, 0);

      // Solid colour 5
      fill_rom(1);
      blit(10, 20, 0, 0, -1);
      check("t2_writes", n_wr, 1024);
      check("t2_first", first_addr, 10250);
      check("t2_last", last_addr, 26153);
      check("t2_data", data_bad, 0);
      check("t2_order", order_bad, 0);
      check("t2_done_cycle", done_k, 2049);

      // Clipped at bottom-right corner
      blit(496, 440, 0, 0, -1);
      check("t3_writes", n_wr, 128);
      check("t3_first", first_addr, 225776);
      check("t3_max", max_addr, 229375);
      check("t3_done_cnt", done_cnt, 1);

      // Back-pressure: 5 stall cycles per write
      blit(0, 0, 5, 0, -1);
      check("t4_writes", n_wr, 1024);
      check("t4_stable", stable_bad, 0);
      check("t4_order", order_bad, 0);
      check("t4_last", last_addr, 15903);
      check("t4_done_cnt", done_cnt, 1);

      // Start re-pulsed mid-blit
      blit(100, 50, 0, 500, -1);
      check("t5_writes", n_wr, 1024);
      check("t5_first", first_addr, 25700);
      check("t5_last", last_addr, 41603);
      check("t5_data", data_bad, 0);
      check("t5_sel", sel_bad, 0);
      check("t5_done_cnt", done_cnt, 1);

      // Reset while a write is pending at pixel 300, then a clean blit
      blit(10, 20, 0, 0, 300);
      check("t6_no_done", done_cnt, 0);
      blit(10, 20, 0, 0, -1);
      check("t6_writes", n_wr, 1024);
      check("t6_first", first_addr, 10250);
      check("t6_done_cnt", done_cnt, 1);

      // Patterned sprite: every 16th pixel is transparent
      fill_rom(2);
      blit(0, 0, 0, 0, -1);
      check("t7_writes", n_wr, 960);
      check("t7_first", first_addr, 1);
      check("t7_data", data_bad, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
